sev_seg_scan_ctrl: RTL and testbench

SEV_SEG_SCAN_CTRL -- requirements
Module: sev_seg_scan_ctrl

---
 rtl/sev_seg_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_sev_seg_scan_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sev_seg_scan_ctrl.sv
// sev_seg_scan_ctrl: time-multiplexed 4-digit seven-segment scanner with per-slot
// blanking, brightness PWM and configurable physical output polarity.
`default_nettype none

module sev_seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] digit_0,
  input  logic [6:0] digit_1,
  input  logic [6:0] digit_2,
  input  logic [6:0] digit_3,
  input  logic [3:0] dots,
  input  logic [3:0] brightness,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] dig_sel,
  output logic [1:0] slot,
  output logic       frame_tick
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] c_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] c_BLANK  = CW'(BLANK_CYCLES);
  localparam logic [CW+4:0] c_ACTIVE = (CW+5)'(SCAN_DIV - BLANK_CYCLES);
  localparam logic [6:0]    c_SEG_INV = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0]    c_DIG_INV = {4{DIG_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2,
    ST_DARK  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   lit_q, lit_d;
  logic [6:0]      pat_q, pat_d;
  logic            dot_q, dot_d;

  logic [6:0]      seg_d;
  logic            dp_d;
  logic [3:0]      dig_d;
  logic [1:0]      slot_d;
  logic            tick_d;

  logic [CW+4:0]   w_prod;
  logic [6:0]      w_pat;
  logic            w_on;

  // The active window times (brightness+1)/16; product width leaves room for x16.
  assign w_prod = c_ACTIVE * ((CW+5)'(brightness) + (CW+5)'(1));

  always_comb begin
    unique case (idx_d)
      2'd0:    w_pat = digit_0;
      2'd1:    w_pat = digit_1;
      2'd2:    w_pat = digit_2;
      default: w_pat = digit_3;
    endcase
  end

  // Outputs are computed from the next-cycle state so the registered outputs
  // line up with the cnt/idx/state of the cycle in which they are visible.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lit_d   = lit_q;
    pat_d   = pat_q;
    dot_d   = dot_q;

    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (state_q == ST_OFF) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == c_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (en && cnt_d == '0)
      lit_d = w_prod[CW+3:4];

    if (en && cnt_d == c_BLANK) begin
      pat_d = w_pat;
      dot_d = dots[idx_d];
    end

    if (!en)
      state_d = ST_OFF;
    else if (cnt_d < c_BLANK)
      state_d = ST_BLANK;
    else if ((cnt_d - c_BLANK) < lit_d)
      state_d = ST_ON;
    else
      state_d = ST_DARK;

    w_on   = (state_d == ST_ON);
    seg_d  = (w_on ? pat_d : 7'd0) ^ c_SEG_INV;
    dp_d   = (w_on & dot_d) ^ SEG_ACTIVE_LOW;
    dig_d  = (w_on ? (4'b0001 << idx_d) : 4'b0000) ^ c_DIG_INV;
    slot_d = en ? idx_d : 2'd0;
    tick_d = en && (cnt_d == c_LAST) && (idx_d == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      idx_q      <= '0;
      lit_q      <= '0;
      pat_q      <= '0;
      dot_q      <= 1'b0;
      seg_out    <= c_SEG_INV;
      dp_out     <= SEG_ACTIVE_LOW;
      dig_sel    <= c_DIG_INV;
      slot       <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lit_q      <= lit_d;
      pat_q      <= pat_d;
      dot_q      <= dot_d;
      seg_out    <= seg_d;
      dp_out     <= dp_d;
      dig_sel    <= dig_d;
      slot       <= slot_d;
      frame_tick <= tick_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sev_seg_scan_ctrl.sv
// tb_sev_seg_scan_ctrl: scenario tasks plus randomized traffic against a
// time-based reference model of the scanner.
`default_nettype none

module tb_sev_seg_scan_ctrl;

  localparam int D = 32;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [6:0] digit_0 = '0, digit_1 = '0, digit_2 = '0, digit_3 = '0;
  logic [3:0] dots = '0;
  logic [3:0] brightness = '0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] dig_sel;
  logic [1:0] slot;
  logic       frame_tick;

  int checks = 0;
  int failures = 0;

  sev_seg_scan_ctrl #(
    .SCAN_DIV(D), .BLANK_CYCLES(B), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .dots(dots), .brightness(brightness),
    .seg_out(seg_out), .dp_out(dp_out), .dig_sel(dig_sel),
    .slot(slot), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: m_t counts cycles since scanning (re)started.
  logic       m_act = 1'b0;
  int         m_t = 0;
  int         m_lit = 0;
  logic [6:0] m_pat = '0;
  logic       m_dot = 1'b0;

  function automatic logic [6:0] pick_digit(int s);
    case (s)
      0: return digit_0;
      1: return digit_1;
      2: return digit_2;
      default: return digit_3;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    int nt, c, s;
    if (rst) begin
      m_act <= 1'b0; m_t <= 0; m_lit <= 0; m_pat <= '0; m_dot <= 1'b0;
    end else if (!en) begin
      m_act <= 1'b0; m_t <= 0;
    end else begin
      nt = m_act ? m_t + 1 : 0;
      c  = nt % D;
      s  = (nt / D) % 4;
      m_act <= 1'b1;
      m_t   <= nt;
      if (c == 0) m_lit <= ((D - B) * (int'(brightness) + 1)) >> 4;
      if (c == B) begin
        m_pat <= pick_digit(s);
        m_dot <= dots[s];
      end
    end
  end

  logic [14:0] exp_vec;
  always_comb begin
    int c, s;
    logic on;
    c  = m_t % D;
    s  = (m_t / D) % 4;
    on = m_act && (c >= B) && ((c - B) < m_lit);
    exp_vec = {~(on ? m_pat : 7'd0), ~(on & m_dot), ~(on ? (4'b0001 << s) : 4'b0000),
               m_act ? 2'(s) : 2'd0, m_act && (c == D - 1) && (s == 3)};
  end

  wire [14:0] act_vec = {seg_out, dp_out, dig_sel, slot, frame_tick};
  localparam logic [14:0] c_IDLE = {7'h7F, 1'b1, 4'hF, 2'd0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  task automatic wait_model_t(int target, string nm);
    int budget = 2000;
    while (!(m_act && m_t == target) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      checks++; failures++;
      $display("FAIL %s timeout: t=%0d required t=%0d", nm, m_t, target);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (act_vec !== c_IDLE) begin
      failures++; $display("FAIL reset_async: got %h required %h", act_vec, c_IDLE);
    end
    tick(); tick();
    checks++;
    if (act_vec !== c_IDLE) begin
      failures++; $display("FAIL reset_hold: got %h required %h", act_vec, c_IDLE);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (act_vec !== c_IDLE) begin
      failures++; $display("FAIL reset_en0: got %h required %h", act_vec, c_IDLE);
    end
  endtask

  task automatic test_full_brightness();
    int last = -1;
    digit_0 = 7'h3F; digit_1 = 7'h06; digit_2 = 7'h5B; digit_3 = 7'h4F;
    dots = 4'b0000; brightness = 4'd15;
    restart();
    for (int cyc = 0; cyc < 4 * 4 * D + 3; cyc++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL full_bright cyc=%0d: got %h required %h", cyc, act_vec, exp_vec);
      end
      if (m_act && (m_t % D) == B + 5) begin
        checks++;
        if (dig_sel !== ~(4'b0001 << ((m_t / D) % 4))) begin
          failures++; $display("FAIL full_bright_dig: got %h required %h", dig_sel, ~(4'b0001 << ((m_t / D) % 4)));
        end
      end
      if (frame_tick) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != 4 * D) begin
            failures++; $display("FAIL frame_period: got %0d required %0d", cyc - last, 4 * D);
          end
        end
        last = cyc;
      end
    end
  endtask

  task automatic test_brightness_levels();
    for (int lvl = 0; lvl < 3; lvl++) begin
      int lit = 0;
      int req;
      brightness = (lvl == 0) ? 4'd7 : (lvl == 1) ? 4'd0 : 4'($urandom_range(15));
      req = ((D - B) * (int'(brightness) + 1)) >> 4;
      restart();
      for (int cyc = 0; cyc < D; cyc++) begin
        tick();
        if (dig_sel !== 4'hF) lit++;
        checks++;
        if (act_vec !== exp_vec) begin
          failures++; $display("FAIL bright%0d cyc=%0d: got %h required %h", lvl, cyc, act_vec, exp_vec);
        end
      end
      checks++;
      if (lit != req) begin
        failures++; $display("FAIL bright_len br=%0d: got %0d required %0d", brightness, lit, req);
      end
    end
  endtask

  task automatic test_midslot_change();
    int lit2 = 0;
    brightness = 4'd15;
    digit_1 = 7'h06;
    restart();
    wait_model_t(D + B + 6, "midslot");
    digit_1 = 7'h77; brightness = 4'd3;
    for (int cyc = 0; cyc < 5 * D; cyc++) begin
      tick();
      if (m_act && (m_t / D) % 4 == 2 && m_t < 4 * D && dig_sel !== 4'hF) lit2++;
      if (m_act && (m_t / D) % 4 == 1 && (m_t % D) == D - 1 && m_t < 4 * D) begin
        checks++;
        if (dig_sel !== 4'hD || seg_out !== ~7'h06) begin
          failures++; $display("FAIL midslot_hold: got dig=%h seg=%h required dig=D seg=%h", dig_sel, seg_out, ~7'h06);
        end
      end
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL midslot cyc=%0d: got %h required %h", cyc, act_vec, exp_vec);
      end
    end
    checks++;
    if (lit2 != 7) begin
      failures++; $display("FAIL midslot_slot2_len: got %0d required 7", lit2);
    end
  endtask

  task automatic test_en_drop();
    brightness = 4'd15;
    restart();
    wait_model_t(2 * D + 10, "en_drop");
    en = 1'b0;
    tick();
    checks++;
    if (act_vec !== c_IDLE) begin
      failures++; $display("FAIL en_drop_idle: got %h required %h", act_vec, c_IDLE);
    end
    en = 1'b1;
    tick();
    checks++;
    if (act_vec !== {7'h7F, 1'b1, 4'hF, 2'd0, 1'b0} || act_vec !== exp_vec) begin
      failures++; $display("FAIL en_rise_blank: got %h required %h", act_vec, exp_vec);
    end
    repeat (B + 2) begin
      tick();
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL en_rise: got %h required %h", act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    brightness = 4'd15;
    restart();
    wait_model_t(B + 8, "async_rst");
    #3 rst = 1'b1;
    #1;
    checks++;
    if (act_vec !== c_IDLE) begin
      failures++; $display("FAIL async_rst: got %h required %h", act_vec, c_IDLE);
    end
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < D + 2; cyc++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL after_rst cyc=%0d: got %h required %h", cyc, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_dots_onehot();
    dots = 4'b0101; brightness = 4'd7;
    digit_0 = 7'($urandom); digit_1 = 7'($urandom); digit_2 = 7'($urandom); digit_3 = 7'($urandom);
    restart();
    for (int cyc = 0; cyc < 4 * 4 * D; cyc++) begin
      tick();
      checks++;
      if ($countones(~dig_sel) > 1) begin
        failures++; $display("FAIL onehot: got %h required at most one low", dig_sel);
      end
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL dots cyc=%0d: got %h required %h", cyc, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(19) == 0) brightness = 4'($urandom);
      if ($urandom_range(9) == 0) dots = 4'($urandom);
      if ($urandom_range(9) == 0) begin
        case ($urandom_range(3))
          0: digit_0 = 7'($urandom);
          1: digit_1 = 7'($urandom);
          2: digit_2 = 7'($urandom);
          default: digit_3 = 7'($urandom);
        endcase
      end
      en = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL random cyc=%0d: got %h required %h", cyc, act_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_brightness();
    test_brightness_levels();
    test_midslot_change();
    test_en_drop();
    test_async_reset();
    test_dots_onehot();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
